// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared constants and types for the FIFO write-port arbiter.
// Optional per-requester beat statistics are enabled with FIFO_ARB_STATS_EN.
package fifo_wr_arbiter_pkg;

   localparam int DATA_WIDTH    = 8;
   localparam int ARB_NUM_REQ   = 4;
   localparam int ARB_MAX_BURST = 4;
   localparam int ARB_STAT_W    = 32;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_e;

   // Index width for n requesters, never narrower than one bit.
   function automatic int id_width(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester and FIFO write-port bundle of the write arbiter.
// master = arbiter side, slave = requesters/FIFO side.
interface fifo_wr_arbiter_if
   import fifo_wr_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = fifo_wr_arbiter_pkg::DATA_WIDTH,
   parameter int NUM_REQ    = fifo_wr_arbiter_pkg::ARB_NUM_REQ
);
   localparam int ID_W = id_width(NUM_REQ);

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_last;
   logic [NUM_REQ-1:0]            req_ready;
   logic                          fifo_full;
   logic                          fifo_wr_en;
   logic [DATA_WIDTH-1:0]         fifo_wr_data;
   logic                          grant_active;
   logic [ID_W-1:0]               grant_id;

   modport master (
      input  req_valid, req_data, req_last, fifo_full,
      output req_ready, fifo_wr_en, fifo_wr_data, grant_active, grant_id
   );

   modport slave (
      output req_valid, req_data, req_last, fifo_full,
      input  req_ready, fifo_wr_en, fifo_wr_data, grant_active, grant_id
   );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request searching upward
// from last_ptr+1 with wrap-around.
module rr_pick #(
   parameter int N    = 4,
   parameter int ID_W = 2
) (
   input  logic [N-1:0]    req,
   input  logic [ID_W-1:0] last_ptr,
   output logic [ID_W-1:0] gnt_id,
   output logic            any
);

   logic found_s;
   int   idx_s;

   assign any = |req;

   // Scan N candidates starting just after the previous winner.
   always_comb begin
      found_s = 1'b0;
      idx_s   = 0;
      gnt_id  = '0;
      for (int k = 1; k <= N; k++) begin
         idx_s = (int'(last_ptr) + k) % N;
         if (!found_s && req[idx_s[ID_W-1:0]]) begin
            found_s = 1'b1;
            gnt_id  = idx_s[ID_W-1:0];
         end else begin
            found_s = found_s;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the fifo_async write port among NUM_REQ requesters.
// Define FIFO_ARB_STATS_EN to add stat_clr/stat_cnt per-requester beat counters.
module fifo_wr_arbiter
   import fifo_wr_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = fifo_wr_arbiter_pkg::DATA_WIDTH,
   parameter int NUM_REQ    = fifo_wr_arbiter_pkg::ARB_NUM_REQ,
   parameter int MAX_BURST  = fifo_wr_arbiter_pkg::ARB_MAX_BURST
) (
   input  logic                     wr_clk,
   input  logic                     wr_rst_n,
   fifo_wr_arbiter_if.master        bus
`ifdef FIFO_ARB_STATS_EN
  ,input  logic                     stat_clr
  ,output logic [NUM_REQ*ARB_STAT_W-1:0] stat_cnt
`endif
);

   localparam int ID_W   = id_width(NUM_REQ);
   localparam int BCNT_W = $clog2(MAX_BURST + 1);

   arb_state_e        state_r, state_n;
   logic [ID_W-1:0]   grant_id_r, grant_id_n;
   logic [ID_W-1:0]   last_ptr_r, last_ptr_n;
   logic [BCNT_W-1:0] beat_cnt_r, beat_cnt_n;
   logic [ID_W-1:0]   pick_id_s;
   logic              pick_any_s;
   logic              busy_s;
   logic              gnt_valid_s;
   logic              gnt_last_s;
   logic              beat_s;
   logic              burst_end_s;

   rr_pick #(
      .N    (NUM_REQ),
      .ID_W (ID_W)
   ) u_pick (
      .req      (bus.req_valid),
      .last_ptr (last_ptr_r),
      .gnt_id   (pick_id_s),
      .any      (pick_any_s)
   );

   assign busy_s      = (state_r == ARB_BUSY);
   assign gnt_valid_s = bus.req_valid[grant_id_r];
   assign gnt_last_s  = bus.req_last[grant_id_r];
   assign beat_s      = busy_s && gnt_valid_s && !bus.fifo_full;
   assign burst_end_s = gnt_last_s || (beat_cnt_r == BCNT_W'(MAX_BURST - 1));

   assign bus.fifo_wr_en   = beat_s;
   assign bus.grant_active = busy_s;
   assign bus.grant_id     = grant_id_r;

   // Ready and write data follow the registered grant; data is zeroed while idle.
   always_comb begin
      bus.req_ready    = '0;
      bus.fifo_wr_data = '0;
      if (busy_s) begin
         bus.req_ready[grant_id_r] = !bus.fifo_full;
         bus.fifo_wr_data          = bus.req_data[int'(grant_id_r)*DATA_WIDTH +: DATA_WIDTH];
      end else begin
         bus.req_ready    = '0;
         bus.fifo_wr_data = '0;
      end
   end

   // Grant state register.
   always_ff @(posedge wr_clk or negedge wr_rst_n) begin
      if (!wr_rst_n) begin
         state_r    <= ARB_IDLE;
         grant_id_r <= '0;
         last_ptr_r <= ID_W'(NUM_REQ - 1);
         beat_cnt_r <= '0;
      end else begin
         state_r    <= state_n;
         grant_id_r <= grant_id_n;
         last_ptr_r <= last_ptr_n;
         beat_cnt_r <= beat_cnt_n;
      end
   end

   // Next-state logic: every release goes back through ARB_IDLE, so grants
   // are separated by one bubble cycle.
   always_comb begin
      state_n    = state_r;
      grant_id_n = grant_id_r;
      last_ptr_n = last_ptr_r;
      beat_cnt_n = beat_cnt_r;
      case (state_r)
         ARB_IDLE: begin
            if (pick_any_s) begin
               grant_id_n = pick_id_s;
               last_ptr_n = pick_id_s;
               beat_cnt_n = '0;
               state_n    = ARB_BUSY;
            end else begin
               state_n    = ARB_IDLE;
            end
         end
         ARB_BUSY: begin
            if (!gnt_valid_s) begin
               state_n = ARB_IDLE;
            end else if (bus.fifo_full) begin
               state_n = ARB_BUSY;
            end else if (burst_end_s) begin
               beat_cnt_n = '0;
               state_n    = ARB_IDLE;
            end else begin
               beat_cnt_n = beat_cnt_r + BCNT_W'(1);
               state_n    = ARB_BUSY;
            end
         end
         default: begin
            state_n    = ARB_IDLE;
            beat_cnt_n = '0;
         end
      endcase
   end

`ifdef FIFO_ARB_STATS_EN
   logic [NUM_REQ-1:0][ARB_STAT_W-1:0] stat_cnt_r;

   // Per-requester accepted-beat counters; clear wins over a same-cycle beat.
   always_ff @(posedge wr_clk or negedge wr_rst_n) begin
      if (!wr_rst_n) begin
         stat_cnt_r <= '0;
      end else if (stat_clr) begin
         stat_cnt_r <= '0;
      end else if (beat_s) begin
         stat_cnt_r[grant_id_r] <= stat_cnt_r[grant_id_r] + ARB_STAT_W'(1);
      end else begin
         stat_cnt_r <= stat_cnt_r;
      end
   end

   assign stat_cnt = stat_cnt_r;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed vector table, hand sequences and a
// randomized run against a burst-level reference model (FIFO_ARB_STATS_EN aware).
module tb_fifo_wr_arbiter;
   import fifo_wr_arbiter_pkg::*;

   localparam int NR  = 4;
   localparam int DW  = 8;
   localparam int MB  = 4;

   logic wr_clk;
   logic wr_rst_n;
   int   total;
   int   bad;

   fifo_wr_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

`ifdef FIFO_ARB_STATS_EN
   logic                    stat_clr;
   logic [NR*ARB_STAT_W-1:0] stat_cnt;
`endif

   fifo_wr_arbiter #(
      .DATA_WIDTH (DW),
      .NUM_REQ    (NR),
      .MAX_BURST  (MB)
   ) dut (
      .wr_clk   (wr_clk),
      .wr_rst_n (wr_rst_n),
      .bus      (bus)
`ifdef FIFO_ARB_STATS_EN
     ,.stat_clr (stat_clr)
     ,.stat_cnt (stat_cnt)
`endif
   );

   initial wr_clk = 1'b0;
   always #5 wr_clk = ~wr_clk;

   typedef struct {
      logic [3:0]  v;
      logic [3:0]  l;
      logic        f;
      logic [31:0] d;
      logic [15:0] exp;
   } vec_t;

   vec_t tbl [24];

   // Packed observation: {grant_active, grant_id, wr_en, wr_data, req_ready}
   function automatic logic [15:0] pk(input logic ga, input logic [1:0] gid, input logic en,
                                      input logic [7:0] wd, input logic [3:0] rdy);
      return {ga, (ga ? gid : 2'd0), en, wd, rdy};
   endfunction

   function automatic vec_t mk(input logic [3:0] v, input logic [3:0] l, input logic f,
                               input logic [31:0] d, input logic ga, input logic [1:0] gid,
                               input logic en, input logic [7:0] wd, input logic [3:0] rdy);
      vec_t r;
      r.v = v; r.l = l; r.f = f; r.d = d;
      r.exp = pk(ga, gid, en, wd, rdy);
      return r;
   endfunction

   function automatic logic [15:0] act_vec();
      return pk(bus.grant_active, bus.grant_id, bus.fifo_wr_en, bus.fifo_wr_data, bus.req_ready);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic f, input logic [31:0] d);
      bus.req_valid = v;
      bus.req_last  = l;
      bus.fifo_full = f;
      bus.req_data  = d;
   endtask

   task automatic next_cycle();
      @(posedge wr_clk);
      #1;
   endtask

   task automatic do_reset();
      drive(4'h0, 4'h0, 1'b0, 32'h0);
      wr_rst_n = 1'b0;
      #3;
      next_cycle();
      wr_rst_n = 1'b1;
   endtask

   // Reference model: a granted burst lasts until last/MB beats/valid drop.
   logic        m_busy;
   int          m_gid;
   int          m_last;
   int          m_beats;
   int          m_stat [NR];

   function automatic logic [15:0] model_exp(input logic [3:0] v, input logic f, input logic [31:0] d);
      logic [3:0] rdy;
      logic [7:0] wd;
      logic       en;
      rdy = 4'h0;
      wd  = 8'h00;
      en  = 1'b0;
      if (m_busy) begin
         wd = d[m_gid*8 +: 8];
         if (!f) rdy[m_gid] = 1'b1;
         en = v[m_gid] && !f;
      end
      return pk(m_busy, 2'(m_gid), en, wd, rdy);
   endfunction

   task automatic model_step(input logic [3:0] v, input logic [3:0] l, input logic f);
      if (!m_busy) begin
         for (int k = 1; k <= NR; k++) begin
            if (!m_busy && v[(m_last + k) % NR]) begin
               m_busy  = 1'b1;
               m_gid   = (m_last + k) % NR;
               m_last  = m_gid;
               m_beats = 0;
            end
         end
      end else if (!v[m_gid]) begin
         m_busy = 1'b0;
      end else if (!f) begin
         m_beats++;
         m_stat[m_gid]++;
         if (l[m_gid] || m_beats == MB) m_busy = 1'b0;
      end
   endtask

   initial begin
      logic [3:0]  rv, rl, prev_v, prev_rdy;
      logic        rf;
      logic [31:0] rd;
      logic [15:0] e;
      logic        prev_ga;
      int          writes, idles;
      int          order [$];

      total = 0;
      bad   = 0;
      wr_rst_n = 1'b0;
      drive(4'h0, 4'h0, 1'b0, 32'h0);
`ifdef FIFO_ARB_STATS_EN
      stat_clr = 1'b0;
`endif

      tbl[0]  = mk(4'h1, 4'h0, 1'b0, 32'h000000A0, 1'b0, 2'd0, 1'b0, 8'h00, 4'h0);
      tbl[1]  = mk(4'h1, 4'h0, 1'b0, 32'h000000A0, 1'b1, 2'd0, 1'b1, 8'hA0, 4'h1);
      tbl[2]  = mk(4'h1, 4'h0, 1'b0, 32'h000000A1, 1'b1, 2'd0, 1'b1, 8'hA1, 4'h1);
      tbl[3]  = mk(4'h1, 4'h0, 1'b0, 32'h000000A2, 1'b1, 2'd0, 1'b1, 8'hA2, 4'h1);
      tbl[4]  = mk(4'h1, 4'h0, 1'b0, 32'h000000A3, 1'b1, 2'd0, 1'b1, 8'hA3, 4'h1);
      tbl[5]  = mk(4'h0, 4'h0, 1'b0, 32'h00000000, 1'b0, 2'd0, 1'b0, 8'h00, 4'h0);
      tbl[6]  = mk(4'h4, 4'h0, 1'b0, 32'h00C00000, 1'b0, 2'd0, 1'b0, 8'h00, 4'h0);
      tbl[7]  = mk(4'h4, 4'h0, 1'b0, 32'h00C00000, 1'b1, 2'd2, 1'b1, 8'hC0, 4'h4);
      tbl[8]  = mk(4'h4, 4'h4, 1'b0, 32'h00C10000, 1'b1, 2'd2, 1'b1, 8'hC1, 4'h4);
      tbl[9]  = mk(4'h0, 4'h0, 1'b0, 32'h00000000, 1'b0, 2'd0, 1'b0, 8'h00, 4'h0);
      tbl[10] = mk(4'h2, 4'h0, 1'b0, 32'h0000B000, 1'b0, 2'd0, 1'b0, 8'h00, 4'h0);
      tbl[11] = mk(4'h2, 4'h0, 1'b0, 32'h0000B000, 1'b1, 2'd1, 1'b1, 8'hB0, 4'h2);
      tbl[12] = mk(4'h2, 4'h0, 1'b1, 32'h0000B100, 1'b1, 2'd1, 1'b0, 8'hB1, 4'h0);
      tbl[13] = mk(4'h2, 4'h0, 1'b1, 32'h0000B100, 1'b1, 2'd1, 1'b0, 8'hB1, 4'h0);
      tbl[14] = mk(4'h2, 4'h0, 1'b1, 32'h0000B100, 1'b1, 2'd1, 1'b0, 8'hB1, 4'h0);
      tbl[15] = mk(4'h2, 4'h0, 1'b0, 32'h0000B100, 1'b1, 2'd1, 1'b1, 8'hB1, 4'h2);
      tbl[16] = mk(4'h2, 4'h0, 1'b0, 32'h0000B200, 1'b1, 2'd1, 1'b1, 8'hB2, 4'h2);
      tbl[17] = mk(4'h2, 4'h0, 1'b0, 32'h0000B300, 1'b1, 2'd1, 1'b1, 8'hB3, 4'h2);
      tbl[18] = mk(4'h0, 4'h0, 1'b0, 32'h00000000, 1'b0, 2'd0, 1'b0, 8'h00, 4'h0);
      tbl[19] = mk(4'h8, 4'h0, 1'b0, 32'hD0000000, 1'b0, 2'd0, 1'b0, 8'h00, 4'h0);
      tbl[20] = mk(4'h9, 4'h0, 1'b0, 32'hD00000E0, 1'b1, 2'd3, 1'b1, 8'hD0, 4'h8);
      tbl[21] = mk(4'h1, 4'h0, 1'b0, 32'hD10000E0, 1'b1, 2'd3, 1'b0, 8'hD1, 4'h8);
      tbl[22] = mk(4'h1, 4'h0, 1'b0, 32'h000000E0, 1'b0, 2'd0, 1'b0, 8'h00, 4'h0);
      tbl[23] = mk(4'h1, 4'h0, 1'b0, 32'h000000E0, 1'b1, 2'd0, 1'b1, 8'hE0, 4'h1);

      // Reset state
      #3;
      check("reset_outputs", {48'h0, act_vec(), 2'b00, bus.grant_id}, 64'h0);
      next_cycle();
      wr_rst_n = 1'b1;

      // Directed vector table
      for (int i = 0; i < 24; i++) begin
         drive(tbl[i].v, tbl[i].l, tbl[i].f, tbl[i].d);
         #1;
         check($sformatf("vec%0d", i), {48'h0, act_vec()}, {48'h0, tbl[i].exp});
         next_cycle();
      end

      // Asynchronous reset in the middle of requester 0's burst
      #2;
      wr_rst_n = 1'b0;
      #1;
      check("async_reset_clear", {48'h0, act_vec(), 2'b00, bus.grant_id}, 64'h0);
      drive(4'hF, 4'h0, 1'b0, 32'h33221100);
      next_cycle();
      wr_rst_n = 1'b1;
      #1;
      check("post_reset_idle", {63'h0, bus.grant_active}, 64'h0);
      next_cycle();
      check("post_reset_first_grant", {61'h0, bus.grant_active, bus.grant_id}, {61'h0, 1'b1, 2'd0});

      // All four requesters continuously valid
      do_reset();
      drive(4'hF, 4'h0, 1'b0, 32'h33221100);
      writes = 0;
      idles = 0;
      prev_ga = 1'b0;
      for (int c = 0; c < 25; c++) begin
         #1;
         if (bus.fifo_wr_en) writes++;
         if (!bus.grant_active) idles++;
         if (bus.grant_active && !prev_ga) order.push_back(int'(bus.grant_id));
         prev_ga = bus.grant_active;
         next_cycle();
      end
      check("rr_write_count", 64'(writes), 64'd20);
      check("rr_idle_cycles", 64'(idles), 64'd5);
      check("rr_grant_count", 64'(order.size()), 64'd5);
      for (int g = 0; g < order.size() && g < 5; g++)
         check($sformatf("rr_order%0d", g), 64'(order[g]), 64'(g % NR));
`ifdef FIFO_ARB_STATS_EN
      check("stat_after_rr", {32'h0, stat_cnt[31:0]}, 64'd8);
      for (int s = 1; s < NR; s++)
         check($sformatf("stat_rr%0d", s), {32'h0, stat_cnt[s*ARB_STAT_W +: ARB_STAT_W]}, 64'd4);
      next_cycle();
      stat_clr = 1'b1;
      #1;
      check("stat_clr_beat_en", {63'h0, bus.fifo_wr_en}, 64'd1);
      next_cycle();
      stat_clr = 1'b0;
      check("stat_clr_zero", {64'(stat_cnt)}, 64'h0);
`endif

      // Randomized run against the reference model
      do_reset();
      m_busy = 1'b0;
      m_gid = 0;
      m_last = NR - 1;
      m_beats = 0;
      for (int s = 0; s < NR; s++) m_stat[s] = 0;
      prev_v = 4'h0;
      prev_rdy = 4'h0;
      rd = 32'h0;
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < NR; i++) begin
            rv[i] = ($urandom_range(0, 3) != 0);
            rl[i] = ($urandom_range(0, 4) == 0);
            if (!(prev_v[i] && !prev_rdy[i])) rd[i*8 +: 8] = 8'($urandom_range(0, 255));
         end
         rf = ($urandom_range(0, 3) == 0);
         drive(rv, rl, rf, rd);
         #1;
         e = model_exp(rv, rf, rd);
         check($sformatf("rand%0d", c), {48'h0, act_vec()}, {48'h0, e});
         prev_v = rv;
         prev_rdy = e[3:0];
         next_cycle();
         model_step(rv, rl, rf);
      end
`ifdef FIFO_ARB_STATS_EN
      for (int s = 0; s < NR; s++)
         check($sformatf("stat_rand%0d", s), {32'h0, stat_cnt[s*ARB_STAT_W +: ARB_STAT_W]}, 64'(m_stat[s]));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
